rpi_serial_rx: RTL and testbench

Receiver for the Raspberry Pi → FPGA direction of the Pi link: samples a Pi-driven serial clock, data and frame line in the `clk_in` domain, assembles MSB-first words, and presents each word through a one-entry valid/ready holding register. It is the counterpart of the FPGA-generated Pi interrupt clock. Downstream logic (audio control/registers) consumes the words. It flags data loss (overrun) and truncated frames (frame error).

---
 rtl/rpi_link_pkg.sv | 5 +
 rtl/rpi_serial_rx_if.sv | 22 ++
 rtl/rpi_serial_rx_sync_edge.sv | 25 ++
 rtl/rpi_serial_rx.sv | 79 +++++++
 tb/tb_rpi_serial_rx.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rpi_link_pkg.sv
// rpi_link_pkg: types and constants shared by the Pi link receiver and interrupt-clock logic
package rpi_link_pkg;
    typedef enum logic {IDLE, SHIFT} rx_state_t;
    localparam int WORD_W_DEF = 16;
endpackage

// File: rtl/rpi_serial_rx_if.sv
// rpi_serial_rx_if: word handshake and status bundle between the Pi receiver and its consumer
interface rpi_serial_rx_if
    import rpi_link_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF
) ();
    logic [WORD_W-1:0] word_out;
    logic word_valid;
    logic word_ready;
    logic overrun;
    logic overrun_clr;
    logic frame_err;
    logic busy;
    modport master (
        output word_out, word_valid, overrun, frame_err, busy,
        input  word_ready, overrun_clr
    );
    modport slave (
        input  word_out, word_valid, overrun, frame_err, busy,
        output word_ready, overrun_clr
    );
endinterface

// File: rtl/rpi_serial_rx_sync_edge.sv
// rpi_sync_edge: multi-flop synchronizer for an asynchronous Pi line with level and rising-edge outputs
module rpi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise
);
    logic [SYNC_STAGES-1:0] chain;
    logic prev;
    // shift the async input through the chain; prev lags the synchronized level by one cycle
    always_ff @(posedge clk_in) begin
        if (reset) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], din};
            prev  <= chain[SYNC_STAGES-1];
        end
    end
    assign level = chain[SYNC_STAGES-1];
    assign rise  = level & ~prev;
endmodule

// File: rtl/rpi_serial_rx.sv
// rpi_serial_rx: Pi-to-FPGA serial word receiver with one-entry valid/ready holding register
module rpi_serial_rx
    import rpi_link_pkg::*;
#(
    parameter int WORD_W      = WORD_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic reset,
    input  logic rpi_clk,
    input  logic rpi_data,
    input  logic rpi_frame,
    rpi_serial_rx_if.master bus
);
    localparam int CNT_W = $clog2(WORD_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WORD_W - 1);
    rx_state_t state, state_d;
    logic [CNT_W-1:0] bit_cnt;
    logic [WORD_W-1:0] shift_reg, word;
    logic clk_rise, data_lvl, frame_lvl;
    logic unused_clk_lvl, unused_data_rise, unused_frame_rise;
    logic shift_en, trunc, done, load, drop;
    rpi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clk (
        .clk_in(clk_in), .reset(reset), .din(rpi_clk), .level(unused_clk_lvl), .rise(clk_rise)
    );
    rpi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_data (
        .clk_in(clk_in), .reset(reset), .din(rpi_data), .level(data_lvl), .rise(unused_data_rise)
    );
    rpi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_frame (
        .clk_in(clk_in), .reset(reset), .din(rpi_frame), .level(frame_lvl), .rise(unused_frame_rise)
    );
    assign word = {shift_reg[WORD_W-2:0], data_lvl};
    // next state: a frame fall wins over a coincident clock edge; mid-word falls flag truncation
    always_comb begin
        state_d  = state;
        shift_en = 1'b0;
        trunc    = 1'b0;
        if (state == IDLE) begin
            state_d = frame_lvl ? SHIFT : IDLE;
        end else if (!frame_lvl) begin
            state_d = IDLE;
            trunc   = bit_cnt != '0;
        end else begin
            shift_en = clk_rise;
        end
    end
    assign done = shift_en && bit_cnt == LAST;
    assign load = done && (!bus.word_valid || bus.word_ready);
    assign drop = done && bus.word_valid && !bus.word_ready;
    assign bus.busy = state == SHIFT;
    // state register
    always_ff @(posedge clk_in) begin
        state <= reset ? IDLE : state_d;
    end
    // bit counter and shift register; the counter wraps at word end so a frame can carry many words
    always_ff @(posedge clk_in) begin
        if (reset) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else begin
            bit_cnt <= (state_d == IDLE || done) ? '0 : bit_cnt + CNT_W'(shift_en);
            if (shift_en) shift_reg <= word;
        end
    end
    // holding register and status flags; a load in the accept cycle keeps valid high with no bubble
    always_ff @(posedge clk_in) begin
        if (reset) begin
            bus.word_out   <= '0;
            bus.word_valid <= 1'b0;
            bus.overrun    <= 1'b0;
            bus.frame_err  <= 1'b0;
        end else begin
            if (load) bus.word_out <= word;
            bus.word_valid <= load || (bus.word_valid && !bus.word_ready);
            bus.overrun    <= drop || (bus.overrun && !bus.overrun_clr);
            bus.frame_err  <= trunc;
        end
    end
endmodule

// File: tb/tb_rpi_serial_rx.sv
// tb_rpi_serial_rx: scoreboard-driven bench for the Pi serial word receiver
module tb_rpi_serial_rx;
    localparam int W = 16;
    logic clk_in = 1'b0;
    logic reset = 1'b1;
    logic rpi_clk = 1'b0;
    logic rpi_data = 1'b0;
    logic rpi_frame = 1'b0;
    int checks = 0;
    int passed = 0;
    logic [W-1:0] exp_q[$];
    rpi_serial_rx_if #(.WORD_W(W)) bus ();
    rpi_serial_rx #(.WORD_W(W), .SYNC_STAGES(2)) dut (
        .clk_in(clk_in), .reset(reset), .rpi_clk(rpi_clk), .rpi_data(rpi_data),
        .rpi_frame(rpi_frame), .bus(bus)
    );
    always #5 clk_in = ~clk_in;
    // every accepted word must be the oldest word still expected
    always @(negedge clk_in) begin
        if (!reset && bus.word_valid && bus.word_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL accept: got %h, required no word", bus.word_out);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if (bus.word_out !== e) $display("FAIL accept: got %h, required %h", bus.word_out, e);
                else passed++;
            end
        end
    end
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask
    task automatic ticks(int n);
        repeat (n) tick();
    endtask
    task automatic send_bit(logic b);
        rpi_clk = 1'b0;
        rpi_data = b;
        ticks(4);
        rpi_clk = 1'b1;
        ticks(4);
    endtask
    task automatic send_bits(logic [W-1:0] w, int n);
        for (int i = W - 1; i >= W - n; i--) send_bit(w[i]);
    endtask
    task automatic send_word(logic [W-1:0] w, bit push);
        if (push) exp_q.push_back(w);
        send_bits(w, W);
    endtask
    task automatic frame_on();
        rpi_clk = 1'b0;
        rpi_frame = 1'b1;
        ticks(4);
    endtask
    task automatic frame_off();
        rpi_clk = 1'b0;
        rpi_frame = 1'b0;
        ticks(4);
    endtask
    task automatic drain();
        int n = 0;
        bus.word_ready = 1'b1;
        while (bus.word_valid && n < 50) begin
            tick();
            n++;
        end
        bus.word_ready = 1'b0;
        checks++;
        if (bus.word_valid !== 1'b0) $display("FAIL drain: word_valid %b, required 0", bus.word_valid);
        else passed++;
    endtask
    task automatic test_reset();
        reset = 1'b1;
        bus.word_ready = 1'b0;
        bus.overrun_clr = 1'b0;
        ticks(3);
        checks++;
        if ({bus.word_out, bus.word_valid, bus.overrun, bus.frame_err, bus.busy} !== '0)
            $display("FAIL reset: out=%h v=%b ovr=%b ferr=%b busy=%b, required all 0",
                     bus.word_out, bus.word_valid, bus.overrun, bus.frame_err, bus.busy);
        else passed++;
        reset = 1'b0;
        tick();
    endtask
    task automatic test_single();
        logic [W-1:0] w = 16'hA5C3;
        frame_on();
        checks++;
        if (bus.busy !== 1'b1) $display("FAIL single busy: got %b, required 1", bus.busy);
        else passed++;
        exp_q.push_back(w);
        send_bits(w, W - 1);
        rpi_clk = 1'b0;
        rpi_data = w[0];
        ticks(4);
        rpi_clk = 1'b1;
        ticks(2);
        @(negedge clk_in);
        checks++;
        if (bus.word_valid !== 1'b0) $display("FAIL single early valid: got %b, required 0", bus.word_valid);
        else passed++;
        tick();
        @(negedge clk_in);
        checks++;
        if (bus.word_valid !== 1'b1) $display("FAIL single latency: word_valid %b, required 1", bus.word_valid);
        else passed++;
        checks++;
        if (bus.word_out !== w) $display("FAIL single word: got %h, required %h", bus.word_out, w);
        else passed++;
        checks++;
        if (bus.overrun !== 1'b0) $display("FAIL single overrun: got %b, required 0", bus.overrun);
        else passed++;
        tick();
        frame_off();
        checks++;
        if (bus.busy !== 1'b0) $display("FAIL single idle busy: got %b, required 0", bus.busy);
        else passed++;
        drain();
    endtask
    task automatic test_back_to_back();
        frame_on();
        fork
            begin
                send_word(16'h1234, 1'b1);
                send_word(16'hFFFF, 1'b1);
            end
            begin
                int n = 0;
                while (!bus.word_valid && n < 400) begin
                    tick();
                    n++;
                end
                checks++;
                if (bus.word_valid !== 1'b1) $display("FAIL b2b first valid: got %b, required 1", bus.word_valid);
                else passed++;
                bus.word_ready = 1'b1;
                tick();
                bus.word_ready = 1'b0;
            end
        join
        frame_off();
        checks++;
        if (bus.overrun !== 1'b0) $display("FAIL b2b overrun: got %b, required 0", bus.overrun);
        else passed++;
        drain();
        checks++;
        if (exp_q.size() != 0) $display("FAIL b2b pending: got %0d words, required 0", exp_q.size());
        else passed++;
    endtask
    task automatic test_overrun();
        frame_on();
        send_word(16'h0001, 1'b1);
        send_word(16'h0002, 1'b0);
        send_word(16'h0003, 1'b0);
        frame_off();
        checks++;
        if (bus.word_out !== 16'h0001) $display("FAIL overrun held word: got %h, required 0001", bus.word_out);
        else passed++;
        checks++;
        if (bus.overrun !== 1'b1) $display("FAIL overrun set: got %b, required 1", bus.overrun);
        else passed++;
        bus.overrun_clr = 1'b1;
        tick();
        bus.overrun_clr = 1'b0;
        checks++;
        if (bus.overrun !== 1'b0) $display("FAIL overrun clear: got %b, required 0", bus.overrun);
        else passed++;
        bus.word_ready = 1'b1;
        tick();
        bus.word_ready = 1'b0;
        checks++;
        if ({bus.word_valid, bus.word_out} !== {1'b0, 16'h0001})
            $display("FAIL overrun accept: v=%b out=%h, required v=0 out=0001", bus.word_valid, bus.word_out);
        else passed++;
        frame_on();
        send_word(16'h0004, 1'b1);
        frame_off();
        checks++;
        if (bus.overrun !== 1'b0) $display("FAIL overrun after clear: got %b, required 0", bus.overrun);
        else passed++;
        drain();
    endtask
    task automatic test_simultaneous();
        logic [W-1:0] w = 16'h8001;
        frame_on();
        send_word(16'h3C3C, 1'b1);
        exp_q.push_back(w);
        send_bits(w, W - 1);
        rpi_clk = 1'b0;
        rpi_data = w[0];
        ticks(4);
        rpi_clk = 1'b1;
        ticks(2);
        bus.word_ready = 1'b1;
        tick();
        bus.word_ready = 1'b0;
        checks++;
        if ({bus.word_valid, bus.word_out, bus.overrun} !== {1'b1, w, 1'b0})
            $display("FAIL simultaneous: v=%b out=%h ovr=%b, required v=1 out=%h ovr=0",
                     bus.word_valid, bus.word_out, bus.overrun, w);
        else passed++;
        tick();
        frame_off();
        drain();
    endtask
    task automatic test_truncated();
        frame_on();
        send_bits(16'hFE00, 7);
        rpi_clk = 1'b0;
        rpi_frame = 1'b0;
        ticks(2);
        checks++;
        if (bus.frame_err !== 1'b0) $display("FAIL trunc early: frame_err %b, required 0", bus.frame_err);
        else passed++;
        tick();
        checks++;
        if (bus.frame_err !== 1'b1) $display("FAIL trunc pulse: frame_err %b, required 1", bus.frame_err);
        else passed++;
        tick();
        checks++;
        if ({bus.frame_err, bus.word_valid} !== 2'b00)
            $display("FAIL trunc end: frame_err %b word_valid %b, required 0 0", bus.frame_err, bus.word_valid);
        else passed++;
        frame_on();
        send_word(16'hBEEF, 1'b1);
        frame_off();
        drain();
    endtask
    task automatic test_reset_mid();
        frame_on();
        send_word(16'h7777, 1'b0);
        send_bits(16'h1234, 9);
        reset = 1'b1;
        rpi_clk = 1'b0;
        tick();
        checks++;
        if ({bus.word_out, bus.word_valid, bus.overrun, bus.frame_err, bus.busy} !== '0)
            $display("FAIL reset mid: out=%h v=%b ovr=%b ferr=%b busy=%b, required all 0",
                     bus.word_out, bus.word_valid, bus.overrun, bus.frame_err, bus.busy);
        else passed++;
        reset = 1'b0;
        ticks(4);
        send_word(16'h5A5A, 1'b1);
        frame_off();
        drain();
    endtask
    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1);
    end
    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_simultaneous();
        test_truncated();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) $display("FAIL scoreboard: %0d words undelivered, required 0", exp_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
